// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive capture path: the receiver FSM
// state encoding and the default bit timing / terminator byte.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   localparam int         DEFAULT_CLK_DIV   = 25;
   localparam logic [7:0] DEFAULT_STOP_BYTE = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO with exact occupancy count and flush.
// The head entry is presented on rd_data_o whenever the FIFO is non-empty
// (zero when empty). A write into a full FIFO is accepted only when a read
// happens in the same cycle. A read on an empty FIFO is ignored. Flush wins
// over a simultaneous write.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-high
//   flush_i    in   empty the FIFO
//   wr_en_i    in   write request
//   wr_data_i  in   write data [WIDTH]
//   rd_en_i    in   read (pop) request
//   rd_data_o  out  head entry [WIDTH]
//   count_o    out  occupancy 0..DEPTH [$clog2(DEPTH)+1]
//   empty_o    out  FIFO empty
//   full_o     out  FIFO full
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_wr;
   logic             do_rd;

   // A read only happens when there is something to read; a write into a
   // full FIFO is allowed only if a read frees a slot in the same cycle.
   always_comb begin
      empty_o = (count == '0);
      full_o  = (count == CW'(DEPTH));
      do_rd   = rd_en_i && !empty_o;
      do_wr   = wr_en_i && (!full_o || do_rd);
   end

   // Pointer and occupancy bookkeeping. Pointers are AW bits wide so they
   // wrap modulo DEPTH on their own; flush returns everything to empty.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

   // Storage array carries no reset; an entry only becomes visible once
   // the pointer bookkeeping says it was written.
   always_ff @(posedge clk) begin
      if (do_wr && !rst && !flush_i) begin
         mem[wr_ptr] <= wr_data_i;
      end
   end

   // Show-ahead output is forced to zero when empty so stale entries never
   // leak out after a flush or reset.
   always_comb begin
      rd_data_o = empty_o ? '0 : mem[rd_ptr];
      count_o   = count;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver (8N1, LSB first, idle high) feeding a show-ahead FIFO.
// Detects a terminator byte (never stored) and reports sticky framing,
// overflow and (optionally) parity errors.
//
// Build option: define UART_RX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit. Without it parity_err_o is 0.
//
// Ports:
//   clk           in   clock
//   rst           in   synchronous reset, active-high
//   rxd_i         in   serial line, asynchronous to clk
//   clr_i         in   flush FIFO and clear sticky flags
//   data_o        out  head-of-FIFO byte (show-ahead) [8]
//   valid_o       out  FIFO non-empty
//   ready_i       in   consumer accepts; pop when valid_o && ready_i
//   count_o       out  FIFO occupancy [$clog2(FIFO_DEPTH)+1]
//   overflow_o    out  sticky: good byte dropped, FIFO full
//   frame_err_o   out  sticky: stop bit sampled low
//   parity_err_o  out  sticky: parity mismatch
//   stop_seen_o   out  sticky: STOP_BYTE received
// ---------------------------------------------------------------------------
module uart_rx_fifo
   import uart_rx_pkg::*;
#(
   parameter int         CLK_DIV    = DEFAULT_CLK_DIV,
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] STOP_BYTE  = DEFAULT_STOP_BYTE
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rxd_i,
   input  logic                          clr_i,
   output logic [7:0]                    data_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          overflow_o,
   output logic                          frame_err_o,
   output logic                          parity_err_o,
   output logic                          stop_seen_o
);

   localparam int            BW      = $clog2(CLK_DIV);
   localparam logic [BW-1:0] HALF_M1 = BW'(CLK_DIV / 2 - 1);
   localparam logic [BW-1:0] LAST    = BW'(CLK_DIV - 1);

   logic          sync1;
   logic          sync2;
   logic          line;
   rx_state_t     state, state_n;
   logic [BW-1:0] bcnt, bcnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shift, shift_n;
   logic          par_bad, par_bad_n;
   logic          push_q, push_n;
   logic          set_stop;
   logic          set_frame;
   logic          fifo_empty;
   logic          fifo_full;
   logic          pop;

   // Two-flop synchronizer; resets to the idle (high) line level so a
   // reset never looks like a start bit by itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rxd_i;
         sync2 <= sync1;
      end
   end

   assign line = sync2;

   // Receiver state register. The push is registered so the FIFO write
   // lands one cycle after the stop-bit sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bcnt    <= '0;
         idx     <= '0;
         shift   <= '0;
         par_bad <= 1'b0;
         push_q  <= 1'b0;
      end else begin
         state   <= state_n;
         bcnt    <= bcnt_n;
         idx     <= idx_n;
         shift   <= shift_n;
         par_bad <= par_bad_n;
         push_q  <= push_n;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic set_parity;
`endif

   // Next-state logic. The start bit is re-checked at its middle to reject
   // glitches; every later bit is sampled one full bit time after that, so
   // samples stay near bit centres. A low stop bit parks the FSM in BREAK
   // until the line recovers, so a held-low line is not read as new frames.
   always_comb begin
      state_n   = state;
      bcnt_n    = bcnt + BW'(1);
      idx_n     = idx;
      shift_n   = shift;
      par_bad_n = par_bad;
      push_n    = 1'b0;
      set_stop  = 1'b0;
      set_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
      set_parity = 1'b0;
`endif
      case (state)
         IDLE: begin
            bcnt_n = '0;
            if (!line) begin
               state_n = START;
            end
         end
         START: begin
            if (bcnt == HALF_M1) begin
               bcnt_n    = '0;
               idx_n     = '0;
               par_bad_n = 1'b0;
               state_n   = line ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bcnt == LAST) begin
               bcnt_n        = '0;
               shift_n[idx]  = line;
               idx_n         = idx + 3'd1;
               if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bcnt == LAST) begin
               bcnt_n = '0;
               if (line != ^shift) begin
                  par_bad_n  = 1'b1;
                  set_parity = 1'b1;
               end
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            if (bcnt == LAST) begin
               bcnt_n = '0;
               if (!line) begin
                  set_frame = 1'b1;
                  state_n   = BREAK;
               end else begin
                  state_n = IDLE;
                  if (!par_bad) begin
                     if (shift == STOP_BYTE) begin
                        set_stop = 1'b1;
                     end else begin
                        push_n = 1'b1;
                     end
                  end
               end
            end
         end
         BREAK: begin
            bcnt_n = '0;
            if (line) begin
               state_n = IDLE;
            end
         end
         default: begin
            bcnt_n  = '0;
            state_n = IDLE;
         end
      endcase
   end

   assign pop = ready_i && !fifo_empty;

   // Sticky status flags; clr_i clears them all. An overflow is only a
   // push that the FIFO could not accept, i.e. full with no pop alongside.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         overflow_o  <= 1'b0;
         frame_err_o <= 1'b0;
         stop_seen_o <= 1'b0;
      end else begin
         if (set_stop) begin
            stop_seen_o <= 1'b1;
         end
         if (set_frame) begin
            frame_err_o <= 1'b1;
         end
         if (push_q && fifo_full && !pop) begin
            overflow_o <= 1'b1;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity error flag exists only in the parity build.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         parity_err_o <= 1'b0;
      end else if (set_parity) begin
         parity_err_o <= 1'b1;
      end
   end
`else
   assign parity_err_o = 1'b0;
`endif

   // The shift register is stable until the next frame's first data
   // sample, so it can serve directly as the write data for push_q.
   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (clr_i),
      .wr_en_i   (push_q),
      .wr_data_i (shift),
      .rd_en_i   (ready_i),
      .rd_data_o (data_o),
      .count_o   (count_o),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

   assign valid_o = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo at 10 ns clock, 25 clocks per bit
// (250 ns/bit), 16-entry FIFO, terminator 0xFF.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int BIT = 25;

   logic       clk;
   logic       rst;
   logic       rxd;
   logic       clr;
   logic       ready;
   logic [7:0] data;
   logic       valid;
   logic [4:0] count;
   logic       overflow;
   logic       frame_err;
   logic       parity_err;
   logic       stop_seen;

   int total;
   int bad;

   uart_rx_fifo #(
      .CLK_DIV    (BIT),
      .FIFO_DEPTH (16),
      .STOP_BYTE  (8'hFF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rxd_i        (rxd),
      .clr_i        (clr),
      .data_o       (data),
      .valid_o      (valid),
      .ready_i      (ready),
      .count_o      (count),
      .overflow_o   (overflow),
      .frame_err_o  (frame_err),
      .parity_err_o (parity_err),
      .stop_seen_o  (stop_seen)
   );

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance n rising edges and land 1 ns after the last one.
   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One comparison: counts it and reports a failure with observed/expected.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Serialise one frame: start, 8 data bits LSB first, optional parity,
   // stop bit at the given level. Line is left at the stop level.
   task automatic applyStimulus(input logic [7:0] b, input logic par, input logic stopb);
      $display("[TB] sending 0x%02h par=%0b stop=%0b", b, par, stopb);
      rxd = 1'b0;
      waitCycles(BIT);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         waitCycles(BIT);
      end
`ifdef UART_RX_PARITY_EN
      rxd = par;
      waitCycles(BIT);
`endif
      rxd = stopb;
      waitCycles(BIT);
   endtask

   // Good frame followed by one idle bit time.
   task automatic sendByte(input logic [7:0] b);
      applyStimulus(b, ^b, 1'b1);
      rxd = 1'b1;
      waitCycles(BIT);
   endtask

   task automatic pulseClear();
      clr = 1'b1;
      waitCycles(1);
      clr = 1'b0;
      waitCycles(1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      rxd   = 1'b1;
      clr   = 1'b0;
      ready = 1'b0;
      @(posedge clk);
      #1;
      waitCycles(4);
      rst = 1'b0;
      waitCycles(2);

      // Reset state.
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_valid", 32'(valid), 32'd0);
      checkOutput("rst_data", 32'(data), 32'd0);
      checkOutput("rst_flags", {28'd0, overflow, frame_err, parity_err, stop_seen}, 32'd0);

      // Three bytes buffered, then drained with ready held high.
      sendByte(8'h41);
      sendByte(8'h42);
      sendByte(8'h43);
      waitCycles(5);
      checkOutput("abc_count", 32'(count), 32'd3);
      checkOutput("abc_head", 32'(data), 32'h41);
      checkOutput("abc_valid", 32'(valid), 32'd1);
      ready = 1'b1;
      waitCycles(1);
      checkOutput("abc_pop1", 32'(data), 32'h42);
      waitCycles(1);
      checkOutput("abc_pop2", 32'(data), 32'h43);
      waitCycles(1);
      checkOutput("abc_empty_valid", 32'(valid), 32'd0);
      checkOutput("abc_empty_count", 32'(count), 32'd0);
      checkOutput("abc_empty_data", 32'(data), 32'd0);
      ready = 1'b0;

      // Terminator byte: flagged, not stored; clear drops the flag.
      sendByte(8'h41);
      sendByte(8'hFF);
      waitCycles(5);
      checkOutput("term_seen", 32'(stop_seen), 32'd1);
      checkOutput("term_count", 32'(count), 32'd1);
      checkOutput("term_head", 32'(data), 32'h41);
      pulseClear();
      checkOutput("term_clr_seen", 32'(stop_seen), 32'd0);
      checkOutput("term_clr_count", 32'(count), 32'd0);

      // Seventeen bytes into sixteen entries: last one dropped.
      for (int i = 0; i < 17; i++) begin
         sendByte(8'(i));
      end
      waitCycles(5);
      checkOutput("ovf_count", 32'(count), 32'd16);
      checkOutput("ovf_flag", 32'(overflow), 32'd1);
      checkOutput("ovf_head", 32'(data), 32'h00);
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checkOutput("ovf_drain", 32'(data), 32'(i));
         waitCycles(1);
      end
      checkOutput("ovf_drained_valid", 32'(valid), 32'd0);
      checkOutput("ovf_sticky", 32'(overflow), 32'd1);
      ready = 1'b0;
      pulseClear();
      checkOutput("ovf_clr", 32'(overflow), 32'd0);

      // 100 ns low glitch is shorter than half a bit: nothing received,
      // and a normal byte afterwards decodes cleanly.
      rxd = 1'b0;
      waitCycles(10);
      rxd = 1'b1;
      waitCycles(2 * BIT);
      checkOutput("glitch_count", 32'(count), 32'd0);
      checkOutput("glitch_flags", {28'd0, overflow, frame_err, parity_err, stop_seen}, 32'd0);
      sendByte(8'h81);
      waitCycles(5);
      checkOutput("glitch_after_count", 32'(count), 32'd1);
      checkOutput("glitch_after_data", 32'(data), 32'h81);
      pulseClear();

      // Low stop bit, line held low 1 us, then a good byte.
      applyStimulus(8'h55, ^8'h55, 1'b0);
      rxd = 1'b0;
      waitCycles(100);
      rxd = 1'b1;
      waitCycles(2 * BIT);
      sendByte(8'h5A);
      waitCycles(5);
      checkOutput("frame_err", 32'(frame_err), 32'd1);
      checkOutput("frame_count", 32'(count), 32'd1);
      checkOutput("frame_data", 32'(data), 32'h5A);
      pulseClear();
      checkOutput("frame_clr", 32'(frame_err), 32'd0);

      // Reset mid-frame with the line still low: the old frame is lost and
      // the low line is taken as a fresh start bit.
      rxd = 1'b0;
      waitCycles(60);
      rst = 1'b1;
      waitCycles(1);
      rst = 1'b0;
      checkOutput("midrst_count", 32'(count), 32'd0);
      sendByte(8'h3C);
      waitCycles(5);
      checkOutput("midrst_after_count", 32'(count), 32'd1);
      checkOutput("midrst_after_data", 32'(data), 32'h3C);
      checkOutput("midrst_frame", 32'(frame_err), 32'd0);
      pulseClear();

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x03 needs parity bit 0.
      applyStimulus(8'h03, 1'b1, 1'b1);
      rxd = 1'b1;
      waitCycles(BIT + 5);
      checkOutput("par_bad_flag", 32'(parity_err), 32'd1);
      checkOutput("par_bad_count", 32'(count), 32'd0);
      applyStimulus(8'h03, 1'b0, 1'b1);
      rxd = 1'b1;
      waitCycles(BIT + 5);
      checkOutput("par_good_count", 32'(count), 32'd1);
      checkOutput("par_good_data", 32'(data), 32'h03);
      checkOutput("par_frame", 32'(frame_err), 32'd0);
`else
      checkOutput("par_tied", 32'(parity_err), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receiver that consumes the SoC UART TX line (8N1, LSB first) and buffers received bytes in a show-ahead FIFO.
- Sits directly downstream of the UART Lite transmitter. Used as the synthesizable capture stage for loopback and bring-up.
- Detects a configurable terminator byte and reports framing and overflow errors.

Parameters:
- CLK_DIV, 25: clock cycles per bit. Must be >= 4.
- FIFO_DEPTH, 16: FIFO entries. Power of 2, >= 2.
- STOP_BYTE, 8'hFF: terminator value. It is never written into the FIFO.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rxd_i  in  1  serial line; idle high; asynchronous to clk
- clr_i  in  1  flush FIFO and clear all sticky flags
- data_o  out  8  head-of-FIFO byte (show-ahead)
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer accepts; pop when valid_o && ready_i
- count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow_o  out  1  sticky: a good byte was dropped because the FIFO was full
- frame_err_o  out  1  sticky: stop bit sampled low
- parity_err_o  out  1  sticky parity error (see Optional Feature)
- stop_seen_o  out  1  sticky: STOP_BYTE received

Behaviour:
- Reset: all outputs 0; data_o 0; synchronizer flops 1; FSM IDLE; pointers 0.
- rxd_i passes through a 2-flop synchronizer. Every reference to "line" below means the synchronized value.
- Bit counter `bcnt` counts 0..CLK_DIV-1. HALF = CLK_DIV/2, floor.
- FSM states:
  - IDLE: line low → START, bcnt=0.
  - START: at bcnt==HALF-1, if line high → IDLE (glitch rejected); else → DATA, bcnt=0, bit index 0.
  - DATA: at bcnt==CLK_DIV-1, sample line into shift[idx], LSB first; after idx 7 → STOP (or PARITY).
  - STOP: at bcnt==CLK_DIV-1, sample the line, then:
    - high and byte==STOP_BYTE: set stop_seen_o; no push.
    - high and any other byte: push.
    - low: set frame_err_o; no push; → BREAK.
    - All outcomes except the low case then → IDLE.
  - BREAK: wait for line high → IDLE. Prevents a low line from being mistaken for back-to-back start bits.
- A push is committed on the cycle after the stop sample. valid_o rises on the following cycle.
- FIFO:
  - Push with the FIFO full and no pop: the byte is dropped and overflow_o is set; contents are unchanged.
  - Full with push and pop in the same cycle: both proceed; count unchanged.
  - Empty with a push: data_o is valid the next cycle; there is no same-cycle bypass.
  - A pop on an empty FIFO is ignored.
  - Pointers wrap modulo FIFO_DEPTH; count_o is exact, 0..FIFO_DEPTH.
- clr_i:
  - Same cycle as a push: clr_i wins; the FIFO ends empty.
  - Does not disturb an in-progress frame.
- rst mid-frame: the frame is abandoned and the FSM goes to IDLE. A line still low after reset is treated as a new start bit.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP, sampled at bcnt==CLK_DIV-1. Even parity.
  - Mismatch sets parity_err_o and the byte is discarded, whether or not it equals STOP_BYTE. The stop bit is still checked.
- UART_RX_PARITY_EN undefined: 8N1 framing; parity_err_o is tied 0.

Decomposition:
- Package uart_rx_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK), default CLK_DIV, default STOP_BYTE.
- Sub-module sync_fifo: parameterized width/depth, show-ahead, with count and flush. It is reusable on the TX side.

Test Plan:
- Send 0x41, 0x42, 0x43 at 250 ns/bit with ready_i=0 → count_o=3, data_o=0x41; then hold ready_i=1 → pops 0x41, 0x42, 0x43, valid_o drops.
- Send 0xFF → stop_seen_o=1, count_o unchanged. Pulse clr_i → stop_seen_o=0.
- Send 17 bytes 0x00..0x10 with ready_i=0, FIFO_DEPTH=16 → count_o=16, overflow_o=1, head=0x00, 0x10 absent.
- Drive rxd_i low for 100 ns (< HALF bits) → no byte, FSM back in IDLE, no error flags.
- Send 0x55 with the stop bit forced low, then hold low 1 µs, then send 0x5A → frame_err_o=1, only 0x5A in the FIFO.
- With UART_RX_PARITY_EN: 0x03 with parity bit 1 → parity_err_o=1, FIFO empty; 0x03 with parity bit 0 → pushed.
